// File: rtl/coop_pkg.sv
// Shared types and constants for the coop-mode UART packet receiver.
package coop_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLON,
    S_DIGIT,
    S_CR,
    S_LF
  } state_e;

  localparam logic [7:0] CH_P     = 8'h50;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;

  // Framing is "P", ":", digits, CR, LF.
  localparam int unsigned PKT_LEN    = 8;
  localparam int unsigned NUM_DIGITS = PKT_LEN - 4;
  localparam int unsigned ACC_W      = 14;
  localparam int unsigned XPOS_W     = 12;
  localparam int unsigned XPOS_MAX   = 4095;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_0) && (b <= CH_9);
  endfunction

endpackage

// File: rtl/clk_divide.sv
// Periodic single-cycle tick generator: tick_o pulses once every CYCLES clocks.
module clk_divide #(
  parameter int unsigned CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             last;

  always_comb begin
    last   = (cnt_q == CNT_W'(CYCLES - 1));
    cnt_d  = last ? '0 : cnt_q + CNT_W'(1);
    tick_d = last;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/coop_packet_rx.sv
// Parses "P:dddd\r\n" x-position packets from the UART RX FIFO.
// Optional link-loss timeout is enabled with macro COOP_RX_TIMEOUT_EN.
module coop_packet_rx
  import coop_pkg::*;
#(
  parameter int unsigned FCLK_HZ    = 100_000_000,
  parameter int unsigned TIMEOUT_MS = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_empty,
  input  logic [7:0]        r_data,
  output logic              rd_uart,
  output logic [XPOS_W-1:0] coop_xpos,
  output logic              coop_valid,
  output logic              pkt_err,
  output logic              coop_link_up
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  // The ms tick needs at least one clock per millisecond and a nonzero timeout.
  if (FCLK_HZ < 1000 || TIMEOUT_MS == 0) begin : g_cfg_check
    $error("coop_packet_rx: FCLK_HZ must be >= 1000 and TIMEOUT_MS > 0");
  end

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [XPOS_W-1:0]  xpos_q, xpos_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               link_q, link_d;
  logic               bad;

  assign rd_uart = !rx_empty && !rst;

`ifdef COOP_RX_TIMEOUT_EN
  localparam int unsigned TICK_CYCLES = FCLK_HZ / 1000;
  localparam int unsigned TO_W        = (TIMEOUT_MS > 1) ? $clog2(TIMEOUT_MS) : 1;

  logic            ms_tick;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  clk_divide #(
    .CYCLES (TICK_CYCLES)
  ) u_ms_tick (
    .clk_i  (clk),
    .rst_i  (rst),
    .tick_o (ms_tick)
  );
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    xpos_d  = xpos_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    link_d  = link_q;
    bad     = 1'b0;
`ifdef COOP_RX_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
`endif

    if (rd_uart) begin
      unique case (state_q)
        S_IDLE: begin
          if (r_data == CH_P) state_d = S_COLON;
        end
        S_COLON: begin
          if (r_data == CH_COLON) begin
            state_d = S_DIGIT;
            acc_d   = '0;
            idx_d   = '0;
          end else begin
            bad = 1'b1;
          end
        end
        S_DIGIT: begin
          if (is_digit(r_data)) begin
            acc_d = ACC_W'(acc_q * ACC_W'(10)) + ACC_W'(r_data - CH_0);
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) state_d = S_CR;
          end else begin
            bad = 1'b1;
          end
        end
        S_CR: begin
          if (r_data == CH_CR) state_d = S_LF;
          else                 bad     = 1'b1;
        end
        S_LF: begin
          if (r_data == CH_LF) begin
            state_d = S_IDLE;
            if (acc_q <= ACC_W'(XPOS_MAX)) begin
              valid_d = 1'b1;
              xpos_d  = acc_q[XPOS_W-1:0];
            end else begin
              err_d = 1'b1;
            end
          end else begin
            bad = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A stray "P" may be the start of the next packet, so resync on it.
    if (bad) begin
      err_d   = 1'b1;
      state_d = (r_data == CH_P) ? S_COLON : S_IDLE;
    end

`ifdef COOP_RX_TIMEOUT_EN
    if (valid_d) begin
      to_cnt_d = '0;
      link_d   = 1'b1;
    end else if (ms_tick && link_q) begin
      if (to_cnt_q == TO_W'(TIMEOUT_MS - 1)) begin
        to_cnt_d = '0;
        link_d   = 1'b0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
`else
    link_d = link_q | valid_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      xpos_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      link_q  <= 1'b0;
`ifdef COOP_RX_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      xpos_q  <= xpos_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      link_q  <= link_d;
`ifdef COOP_RX_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  assign coop_xpos    = xpos_q;
  assign coop_valid   = valid_q;
  assign pkt_err      = err_q;
  assign coop_link_up = link_q;

endmodule

// File: tb/tb_coop_packet_rx.sv
// Bench for coop_packet_rx: directed packets plus a random stream checked against
// a byte-level packet matcher.
module tb_coop_packet_rx;

  localparam int unsigned TMO = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_empty;
  logic [7:0]  r_data;
  logic        rd_uart;
  logic [11:0] coop_xpos;
  logic        coop_valid;
  logic        pkt_err;
  logic        coop_link_up;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;

  logic [7:0]  m_buf[$];
  logic [11:0] m_xpos;
  bit          m_valid, m_err, m_seen;
  int          m_since;

  coop_packet_rx #(
    .FCLK_HZ    (1000),
    .TIMEOUT_MS (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_empty     (rx_empty),
    .r_data       (r_data),
    .rd_uart      (rd_uart),
    .coop_xpos    (coop_xpos),
    .coop_valid   (coop_valid),
    .pkt_err      (pkt_err),
    .coop_link_up (coop_link_up)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Byte required at a given position of a packet that has already started with "P".
  function automatic bit fits(input int pos, input logic [7:0] b);
    case (pos)
      1:          return b == 8'h3A;
      2, 3, 4, 5: return b >= 8'h30 && b <= 8'h39;
      6:          return b == 8'h0D;
      7:          return b == 8'h0A;
      default:    return 1'b0;
    endcase
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int v;
    if (m_buf.size() == 0) begin
      if (b == 8'h50) m_buf.push_back(b);
    end else if (!fits(m_buf.size(), b)) begin
      m_err = 1'b1;
      m_buf.delete();
      if (b == 8'h50) m_buf.push_back(b);
    end else begin
      m_buf.push_back(b);
      if (m_buf.size() == 8) begin
        v = 1000 * (m_buf[2] - 48) + 100 * (m_buf[3] - 48) + 10 * (m_buf[4] - 48) + (m_buf[5] - 48);
        if (v <= 4095) begin
          m_valid = 1'b1;
          m_xpos  = 12'(v);
          m_seen  = 1'b1;
          m_since = 0;
        end else begin
          m_err = 1'b1;
        end
        m_buf.delete();
      end
    end
  endtask

  task automatic cycle(input bit empty, input logic [7:0] data);
    rx_empty = empty;
    r_data   = data;
    #1;
    check("rd_uart", 32'(rd_uart), 32'(!empty));
    @(posedge clk);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (m_since < 1000) m_since++;
    if (!empty) model_byte(data);
    #1;
    if (coop_valid === 1'b1) n_valid++;
    if (pkt_err === 1'b1) n_err++;
    check("coop_valid", 32'(coop_valid), 32'(m_valid));
    check("pkt_err", 32'(pkt_err), 32'(m_err));
    check("coop_xpos", 32'(coop_xpos), 32'(m_xpos));
`ifdef COOP_RX_TIMEOUT_EN
    if (m_since < TMO - 1 || m_since > TMO + 1)
      check("link_up", 32'(coop_link_up), 32'(m_seen && m_since < TMO));
`else
    check("link_up", 32'(coop_link_up), 32'(m_seen));
`endif
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_empty = 1'b0;
    r_data   = 8'h50;
    #1;
    check("rd_uart_in_rst", 32'(rd_uart), 32'd0);
    @(posedge clk);
    m_buf.delete();
    m_xpos  = '0;
    m_seen  = 1'b0;
    m_since = 0;
    #1;
    rst      = 1'b0;
    rx_empty = 1'b1;
    check("rst_xpos", 32'(coop_xpos), 32'd0);
    check("rst_valid", 32'(coop_valid), 32'd0);
    check("rst_err", 32'(pkt_err), 32'd0);
    check("rst_link", 32'(coop_link_up), 32'd0);
  endtask

  task automatic send(input string s, input int maxgap);
    for (int i = 0; i < s.len(); i++) begin
      int g = int'($urandom_range(maxgap, 0));
      for (int k = 0; k < g; k++) cycle(1'b1, 8'($urandom));
      cycle(1'b0, 8'(s[i]));
    end
  endtask

  initial begin
    int v0, e0;
    string s;
    rst      = 1'b1;
    rx_empty = 1'b1;
    r_data   = 8'h00;
    m_xpos   = '0;
    m_seen   = 1'b0;
    m_since  = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Back-to-back packet.
    v0 = n_valid;
    send("P:0321\r\n", 0);
    check("b2b_xpos", 32'(coop_xpos), 32'd321);
    check("b2b_valid_cnt", 32'(n_valid - v0), 32'd1);
    check("b2b_link", 32'(coop_link_up), 32'd1);

    // Same packet with FIFO gaps between bytes.
    v0 = n_valid;
    send("P:0321\r\n", 5);
    check("gap_xpos", 32'(coop_xpos), 32'd321);
    check("gap_valid_cnt", 32'(n_valid - v0), 32'd1);

    // Bad digit then out-of-range value.
    v0 = n_valid; e0 = n_err;
    send("P:03a1\r\n", 2);
    send("P:5000\r\n", 2);
    check("bad_err_cnt", 32'(n_err - e0), 32'd2);
    check("bad_valid_cnt", 32'(n_valid - v0), 32'd0);
    check("bad_xpos", 32'(coop_xpos), 32'd321);

    // Junk, then a restarted header.
    v0 = n_valid; e0 = n_err;
    send("xxP:P:0007\r\n", 1);
    check("resync_err_cnt", 32'(n_err - e0), 32'd1);
    check("resync_valid_cnt", 32'(n_valid - v0), 32'd1);
    check("resync_xpos", 32'(coop_xpos), 32'd7);

    // Reset in the middle of a packet.
    send("P:12", 1);
    v0 = n_valid; e0 = n_err;
    do_reset();
    send("34\r\n", 1);
    check("midrst_valid_cnt", 32'(n_valid - v0), 32'd0);
    check("midrst_err_cnt", 32'(n_err - e0), 32'd0);
    send("P:0042\r\n", 1);
    check("midrst_xpos", 32'(coop_xpos), 32'd42);
    check("midrst_valid_cnt2", 32'(n_valid - v0), 32'd1);

    // Silence after a valid packet.
    for (int k = 0; k < 2 * TMO; k++) cycle(1'b1, 8'($urandom));
`ifdef COOP_RX_TIMEOUT_EN
    check("silence_link", 32'(coop_link_up), 32'd0);
`else
    check("silence_link", 32'(coop_link_up), 32'd1);
`endif

    // Random mix of good, overflowing, corrupted packets and junk.
    for (int p = 0; p < 60; p++) begin
      case ($urandom_range(4, 0))
        0, 1: send($sformatf("P:%04d\r\n", $urandom_range(4095, 0)), 3);
        2:    send($sformatf("P:%04d\r\n", $urandom_range(9999, 4096)), 3);
        3: begin
          s = $sformatf("P:%04d\r\n", $urandom_range(9999, 0));
          s.putc(int'($urandom_range(7, 1)), byte'($urandom_range(255, 1)));
          send(s, 3);
        end
        default: begin
          for (int k = 0; k < int'($urandom_range(4, 1)); k++)
            cycle(1'b0, 8'($urandom_range(255, 0)));
        end
      endcase
    end
    send("P:4095\r\n", 0);
    check("max_xpos", 32'(coop_xpos), 32'd4095);
    e0 = n_err;
    send("P:4096\r\n", 0);
    check("over_err_cnt", 32'(n_err - e0), 32'd1);
    check("over_xpos", 32'(coop_xpos), 32'd4095);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
